// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Optional feature macro: MC_CTRL_JUMP_EN (enables the JUMP state for opcode 000010).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic    pc_write;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    srcb_e   alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decoder; write/request strobes are gated off during reset.
// Optional feature macro: MC_CTRL_JUMP_EN.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_rst_n,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  output ctrl_t  o_ctrl
);

  ctrl_t w_c;

  always_comb begin
    w_c = '0;
    case (i_state)
      S_FETCH: begin
        w_c.mem_read  = 1'b1;
        w_c.alu_src_b = SRCB_FOUR;
        w_c.ir_write  = i_mem_ready;
        w_c.pc_write  = i_mem_ready;
      end
      S_DECODE: w_c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_c.mem_read = 1'b1;
        w_c.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_c.reg_write  = 1'b1;
        w_c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_c.mem_write = 1'b1;
        w_c.iord      = 1'b1;
      end
      S_EXEC: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_c.reg_write = 1'b1;
        w_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_op    = ALU_SUB;
        w_c.pc_src    = PC_ALUOUT;
        w_c.pc_write  = i_zero;
      end
      S_ADDIEX: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: w_c.reg_write = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        w_c.pc_src   = PC_JUMP;
        w_c.pc_write = 1'b1;
      end
`endif
      default: w_c = '0;
    endcase
    // Reset already holds state at FETCH; only the strobes need masking here.
    if (!i_rst_n) begin
      w_c.pc_write  = 1'b0;
      w_c.ir_write  = 1'b0;
      w_c.mem_read  = 1'b0;
      w_c.mem_write = 1'b0;
      w_c.reg_write = 1'b0;
    end
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic, sticky illegal flag.
// Optional feature macro: MC_CTRL_JUMP_EN (opcode 000010 -> JUMP; otherwise it is illegal).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mc_ctrl_if.master  bus
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  logic   w_illegal_set;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal_set) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_illegal_set = 1'b0;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         w_next = S_JUMP;
`endif
          default: begin
            w_next        = S_FETCH;
            w_illegal_set = 1'b1;
          end
        endcase
      end
      // The IR still holds the lw/sw opcode here, so it picks the access direction.
      S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_rst_n     (rst_n),
    .i_mem_ready (bus.mem_ready),
    .i_zero      (bus.zero),
    .o_ctrl      (w_ctrl)
  );

  assign bus.pc_write   = w_ctrl.pc_write;
  assign bus.iord       = w_ctrl.iord;
  assign bus.mem_read   = w_ctrl.mem_read;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.ir_write   = w_ctrl.ir_write;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.pc_src     = w_ctrl.pc_src;
  assign bus.state      = r_state;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm against an instruction-plan reference model.
module tb_mc_ctrl_fsm;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mc_ctrl_if bus();

  mc_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: an instruction is a list of state codes; waits repeat the current entry.
  int plan[$];
  int pos;
  bit exp_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] outvec();
    return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src};
  endfunction

  // Each control field written as its own rule over the state code.
  function automatic logic [14:0] expvec(input int s, input bit mr, input bit z);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa;
    logic [1:0] sb, aop, psrc;
    mrd  = (s == 0) || (s == 3);
    iord = (s == 3) || (s == 5);
    mwr  = (s == 5);
    irw  = (s == 0) && mr;
    pcw  = ((s == 0) && mr) || ((s == 8) && z) || (s == 11);
    rw   = (s == 4) || (s == 7) || (s == 10);
    rdst = (s == 7);
    m2r  = (s == 4);
    sa   = (s == 2) || (s == 6) || (s == 8) || (s == 9);
    sb   = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : ((s == 2) || (s == 9)) ? 2'd2 : 2'd0;
    aop  = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
    psrc = (s == 8) ? 2'd1 : (s == 11) ? 2'd2 : 2'd0;
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, psrc};
  endfunction

  task automatic start_instr(input logic [5:0] op);
    bus.opcode = op;
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    case (op)
      6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2); plan.push_back(5); end
      6'b000000: begin plan.push_back(6); plan.push_back(7); end
      6'b000100: plan.push_back(8);
      6'b001000: begin plan.push_back(9); plan.push_back(10); end
`ifdef MC_CTRL_JUMP_EN
      6'b000010: plan.push_back(11);
`endif
      default: ;
    endcase
    pos = 0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit mr, input bit z);
    int s;
    s = plan[pos];
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
    chk("state", 32'(bus.state), 32'(s));
    chk("ctrl", 32'(outvec()), 32'(expvec(s, mr, z)));
    chk("illegal", 32'(bus.illegal), 32'(exp_ill));
    @(posedge clk);
    if (s == 1 && plan.size() == 2) exp_ill = 1'b1;
    if (!(((s == 0) || (s == 3) || (s == 5)) && !mr)) pos++;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op);
    int guard;
    guard = 0;
    start_instr(op);
    while (pos < plan.size()) begin
      step(($urandom_range(0, 3) != 0) || (guard > 40), 1'($urandom));
      guard++;
    end
  endtask

  function automatic logic [5:0] rand_op(input bit with_illegal);
    int k;
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
`ifdef MC_CTRL_JUMP_EN
    k = with_illegal ? $urandom_range(0, 6) : $urandom_range(0, 5);
`else
    k = with_illegal ? $urandom_range(0, 6) : $urandom_range(0, 4);
`endif
    return ops[k];
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_ill = 1'b0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ctrl", 32'(outvec()), 32'h0010);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // lw, no waits: 5 cycles, writeback only in the last one
    start_instr(6'b100011);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("lw_len", 32'(pos), 32'd5);

    // sw with two waits in MEMWR
    start_instr(6'b101011);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk("sw_len", 32'(pos), 32'd4);

    // beq taken and not taken
    start_instr(6'b000100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    start_instr(6'b000100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // three FETCH waits then the fetch completes
    start_instr(6'b000000);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    while (pos < plan.size()) step(1'b1, 1'b0);

    for (int n = 0; n < 150; n++) run_instr(rand_op(1'b0));

    // unknown opcode sets the sticky flag
    start_instr(6'b111111);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("ill_set", 32'(bus.illegal), 32'd1);
    run_instr(6'b000010);

    for (int n = 0; n < 150; n++) run_instr(rand_op(1'b1));

    // reset mid-MEMRD abandons the load
    start_instr(6'b100011);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    chk("pre_rst_state", 32'(bus.state), 32'd3);
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_ctrl", 32'(outvec()), 32'h0010);
    chk("mid_rst_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_state", 32'(bus.state), 32'd0);
    chk("held_rst_ctrl", 32'(outvec()), 32'h0010);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ill = 1'b0;
    run_instr(6'b000000);
    for (int n = 0; n < 20; n++) run_instr(rand_op(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select (address, ALU operands, register destination, writeback source, next-PC) and every write strobe. It sits beside the shared 32-bit 2:1 and 4:1 select muxes and the ALU. It stalls on a memory-ready handshake so the single shared memory can take wait states.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction-register bits [31:26].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC load enable.
- `iord`  out  1  address mux select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction-register load.
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `alu_op`  out  2  ALU op: 00 = add, 01 = sub, 10 = decode funct.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding (debug).
- `illegal`  out  1  sticky unknown-opcode flag.

## Operation
- Supported opcodes:
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 001000 addi
  - 000010 j
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: lw/sw → MEMADR; R-type → EXEC; beq → BRANCH; addi → ADDIEX; j → JUMP.
  - Any other opcode sets `illegal` and returns to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Any output not listed for a state is 0.
- `illegal` clears only on reset.
- Unused state encodings 12–15 go to FETCH on the next edge with all strobes 0.

## Timing
- Outputs decode combinationally from `state`, plus `mem_ready` (FETCH strobes) and `zero` (BRANCH). The state register is the only timing element besides `illegal`.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Request outputs and iord stay stable for the whole wait.
- Reset:
  - rst_n=0 forces state=FETCH and illegal=0 immediately.
  - While rst_n=0, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0. Selects show their FETCH values.
  - Reset asserted mid-instruction abandons it; no strobe fires afterwards.
- First fetch request: the first rising edge after rst_n deasserts finds mem_read=1 in FETCH.

## Configuration
- `MC_CTRL_JUMP_EN` defined:
  - Opcode 000010 goes to JUMP.
  - pc_src=10 is reachable.
- `MC_CTRL_JUMP_EN` undefined:
  - JUMP state is absent.
  - Opcode 000010 is treated as illegal.
  - pc_src never equals 10.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings
  - opcode constants
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, `mc_ctrl_outdec`: a purely combinational state-to-output decoder. `mc_ctrl_fsm` keeps the state register, next-state logic and the `illegal` flag.

## Test plan
- lw with mem_ready=1 → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in the 5th cycle.
- sw with mem_ready low 2 cycles in MEMWR → mem_write=1 and iord=1 held for 3 cycles. Total 6 cycles. reg_write never 1.
- beq with zero=1 → pc_write=1, pc_src=01 in BRANCH. With zero=0 → pc_write=0. Both take 3 cycles.
- FETCH with mem_ready=0 for 3 cycles → ir_write=0 and pc_write=0 throughout, then both 1 for exactly 1 cycle.
- Opcode 111111 → illegal=1 after DECODE, return to FETCH, flag stays 1 until rst_n=0. With the macro undefined, 000010 behaves the same.
- rst_n pulsed low during MEMRD → state=0 at once, all strobes 0 while low, fetch resumes after release.
